// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between a UART receiver and its consumer: registered reads, occupancy flags, sticky overrun.
// Define UART_RX_FIFO_LEVEL_EN to expose the occupancy count on level_o.
module uart_rx_fifo #(
    parameter int D_WIDTH    = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int WATERMARK  = 12
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [D_WIDTH-1:0]   rx_byte_i,
    input  logic                 rx_done_i,
    input  logic                 rd_en_i,
    output logic [D_WIDTH-1:0]   rd_data_o,
    output logic                 rd_valid_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 almost_full_o,
    output logic                 overrun_o,
    input  logic                 clr_overrun_i
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]  level_o
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] WM_C    = (ADDR_WIDTH+1)'(WATERMARK);

    logic [D_WIDTH-1:0]    mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic [D_WIDTH-1:0]    rd_data_reg;
    logic                  rd_valid_reg;
    logic                  overrun_reg, overrun_next;

    logic wr_accept;
    logic rd_accept;
    logic wr_drop;

    // A read at full frees a slot in the same cycle, so a simultaneous write is still accepted.
    assign rd_accept = rd_en_i && !empty_o;
    assign wr_accept = rx_done_i && (!full_o || rd_accept);
    assign wr_drop   = rx_done_i && !wr_accept;

    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        count_next   = count_reg;
        overrun_next = overrun_reg;
        if (wr_accept) begin
            wr_ptr_next = wr_ptr_reg + ADDR_WIDTH'(1);
        end
        if (rd_accept) begin
            rd_ptr_next = rd_ptr_reg + ADDR_WIDTH'(1);
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count_reg + (ADDR_WIDTH+1)'(1);
            2'b01:   count_next = count_reg - (ADDR_WIDTH+1)'(1);
            default: count_next = count_reg;
        endcase
        // A fresh drop takes priority over a clear requested in the same cycle.
        if (wr_drop) begin
            overrun_next = 1'b1;
        end else if (clr_overrun_i) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overrun_reg  <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overrun_reg  <= overrun_next;
            rd_valid_reg <= rd_accept;
        end
    end

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (!reset_i && wr_accept) begin
            mem[wr_ptr_reg] <= rx_byte_i;
        end
    end

    // Read-before-write ordering returns the oldest entry when both ports hit the same slot at full.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_data_reg <= '0;
        end else if (rd_accept) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    assign rd_data_o     = rd_data_reg;
    assign rd_valid_o    = rd_valid_reg;
    assign overrun_o     = overrun_reg;
    assign empty_o       = (count_reg == '0);
    assign full_o        = (count_reg == DEPTH_C);
    assign almost_full_o = (count_reg >= WM_C);
`ifdef UART_RX_FIFO_LEVEL_EN
    assign level_o       = count_reg;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed checks for uart_rx_fifo: a cycle table for basic flow and reset, plus hand-written fill/overrun/full sequences.
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] rx_byte;
    logic       rx_done;
    logic       rd_en;
    logic       clr_overrun;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       overrun;
`ifdef UART_RX_FIFO_LEVEL_EN
    logic [4:0] level;
`endif

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.D_WIDTH(8), .ADDR_WIDTH(4), .WATERMARK(12)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .rx_byte_i     (rx_byte),
        .rx_done_i     (rx_done),
        .rd_en_i       (rd_en),
        .rd_data_o     (rd_data),
        .rd_valid_o    (rd_valid),
        .empty_o       (empty),
        .full_o        (full),
        .almost_full_o (almost_full),
        .overrun_o     (overrun),
        .clr_overrun_i (clr_overrun)
`ifdef UART_RX_FIFO_LEVEL_EN
        ,
        .level_o       (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       done;
        logic [7:0] din;
        logic       rd;
        logic       clr;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_empty;
        logic       e_full;
        logic       e_af;
        logic       e_ovr;
        logic [4:0] e_lvl;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic cycle(input logic rst, input logic done, input logic [7:0] din,
                         input logic rd, input logic clr);
        reset       = rst;
        rx_done     = done;
        rx_byte     = din;
        rd_en       = rd;
        clr_overrun = clr;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        rx_done     = 1'b0;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [7:0] d,
                              input logic e, input logic f, input logic af,
                              input logic ov, input logic [4:0] lvl);
        chk({tag, ".rd_valid"},    {7'd0, rd_valid},    {7'd0, v});
        chk({tag, ".rd_data"},     rd_data,             d);
        chk({tag, ".empty"},       {7'd0, empty},       {7'd0, e});
        chk({tag, ".full"},        {7'd0, full},        {7'd0, f});
        chk({tag, ".almost_full"}, {7'd0, almost_full}, {7'd0, af});
        chk({tag, ".overrun"},     {7'd0, overrun},     {7'd0, ov});
`ifdef UART_RX_FIFO_LEVEL_EN
        chk({tag, ".level"},       {3'd0, level},       {3'd0, lvl});
`else
        if (lvl > 5'd16) $display("note: bad expected level %0d", lvl);
`endif
    endtask

    initial begin
        reset = 1'b1; rx_done = 1'b0; rx_byte = 8'h00; rd_en = 1'b0; clr_overrun = 1'b0;

        //                rst done din    rd clr  valid data  emp full af ovr lvl
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[1]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1};
        vecs[2]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[7]  = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[9]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1};
        vecs[10] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2};
        vecs[11] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3};
        vecs[12] = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4};
        vecs[13] = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5};
        vecs[14] = '{1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].rst, vecs[i].done, vecs[i].din, vecs[i].rd, vecs[i].clr);
            $display("vec %0d: rst=%0b done=%0b din=%02h rd=%0b -> valid=%0b data=%02h empty=%0b full=%0b af=%0b ovr=%0b",
                     i, vecs[i].rst, vecs[i].done, vecs[i].din, vecs[i].rd,
                     rd_valid, rd_data, empty, full, almost_full, overrun);
            expect_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data, vecs[i].e_empty,
                       vecs[i].e_full, vecs[i].e_af, vecs[i].e_ovr, vecs[i].e_lvl);
        end

        // Fill 0x00..0x0F, watching the watermark and full thresholds.
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b0, 1'b1, 8'(k - 1), 1'b0, 1'b0);
            $display("fill %0d: din=%02h empty=%0b full=%0b af=%0b", k, 8'(k - 1), empty, full, almost_full);
            expect_out($sformatf("fill%0d", k), 1'b0, 8'h00, 1'b0, (k == 16), (k >= 12), 1'b0, 5'(k));
        end
        cycle(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        $display("drop: din=ff full=%0b ovr=%0b", full, overrun);
        expect_out("drop_ff", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 5'd16);
        for (int k = 0; k < 16; k++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            $display("drain %0d: valid=%0b data=%02h", k, rd_valid, rd_data);
            expect_out($sformatf("drain%0d", k), 1'b1, 8'(k), (k == 15), 1'b0, ((15 - k) >= 12), 1'b1, 5'(15 - k));
        end

        // Refill 0x20..0x2F, then exercise clear-vs-drop priority.
        for (int k = 0; k < 16; k++) cycle(1'b0, 1'b1, 8'h20 + 8'(k), 1'b0, 1'b1);
        expect_out("refill", 1'b0, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 5'd16);
        cycle(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
        $display("drop2: ovr=%0b", overrun);
        expect_out("drop_99", 1'b0, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b1, 5'd16);
        cycle(1'b0, 1'b1, 8'h98, 1'b0, 1'b1);
        $display("clr+drop: ovr=%0b", overrun);
        expect_out("clr_with_drop", 1'b0, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b1, 5'd16);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        $display("clr: ovr=%0b", overrun);
        expect_out("clr_alone", 1'b0, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 5'd16);

        // Simultaneous write and read at full.
        cycle(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        $display("wr+rd at full: valid=%0b data=%02h full=%0b ovr=%0b", rd_valid, rd_data, full, overrun);
        expect_out("full_wr_rd", 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 5'd16);
        for (int k = 0; k < 16; k++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            $display("drain2 %0d: valid=%0b data=%02h", k, rd_valid, rd_data);
            expect_out($sformatf("drain2_%0d", k), 1'b1, (k == 15) ? 8'h55 : 8'h21 + 8'(k),
                       (k == 15), 1'b0, ((15 - k) >= 12), 1'b0, 5'(15 - k));
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        expect_out("idle_hold", 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, byte width matching the receiver output.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, giving depth 2**ADDR_WIDTH (16 entries).
REQ-003 SHALL have parameter WATERMARK, default 12, the threshold for almost_full_o.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port rx_byte_i, input, D_WIDTH, received byte from the receiver FSM.
REQ-007 SHALL have port rx_done_i, input, 1, one-cycle strobe; rx_byte_i valid this cycle.
REQ-008 SHALL have port rd_en_i, input, 1, consumer read request.
REQ-009 SHALL have port rd_data_o, output, D_WIDTH, registered read data.
REQ-010 SHALL have port rd_valid_o, output, 1, one-cycle pulse qualifying rd_data_o.
REQ-011 SHALL have port empty_o, output, 1, FIFO holds zero entries.
REQ-012 SHALL have port full_o, output, 1, FIFO holds 2**ADDR_WIDTH entries.
REQ-013 SHALL have port almost_full_o, output, 1, occupancy >= WATERMARK.
REQ-014 SHALL have port overrun_o, output, 1, sticky flag: a received byte was dropped.
REQ-015 SHALL have port clr_overrun_i, input, 1, clears overrun_o.

Function
REQ-016 SHALL store data in a 2**ADDR_WIDTH x D_WIDTH array; write and read pointers ADDR_WIDTH bits wide, wrapping modulo depth; occupancy counter ADDR_WIDTH+1 bits wide.
REQ-017 SHALL accept a write when rx_done_i=1 and (full_o=0 or an accepted read occurs the same cycle), storing rx_byte_i at the write pointer and incrementing it.
REQ-018 SHALL accept a read when rd_en_i=1 and empty_o=0; rd_data_o takes the entry at the read pointer on the next edge, rd_valid_o=1 for exactly that one cycle, and the read pointer increments.
REQ-019 SHALL ignore rd_en_i when empty_o=0 does not hold, including a same-cycle write into an empty FIFO (no fall-through); rd_valid_o stays 0 and rd_data_o holds its value.
REQ-020 SHALL keep occupancy unchanged when a write and a read are both accepted in one cycle, including at full (no overrun).
REQ-021 SHALL drop rx_byte_i and set overrun_o on the next edge when rx_done_i=1, full_o=1 and no read is accepted that cycle; stored contents and pointers are unchanged.
REQ-022 SHALL clear overrun_o on the edge after clr_overrun_i=1; a new overrun in the same cycle as clr_overrun_i SHALL win (overrun_o stays 1).
REQ-023 SHALL derive empty_o, full_o and almost_full_o from the registered occupancy, valid in the cycle after the update.
REQ-024 SHALL hold rd_data_o stable between reads.

Reset
REQ-025 SHALL, while reset_i=1 at a rising edge, set pointers and occupancy to 0, rd_data_o=0, rd_valid_o=0, overrun_o=0, empty_o=1, full_o=0, almost_full_o=0.
REQ-026 SHALL discard all stored entries on reset, including mid-operation; writes and reads in a reset cycle SHALL have no effect.
REQ-027 SHALL not require the array contents to be reset.

Configuration
REQ-028 SHALL, with macro UART_RX_FIFO_LEVEL_EN defined, add output port level_o (ADDR_WIDTH+1 bits) equal to the registered occupancy, reset value 0.
REQ-029 SHALL, without UART_RX_FIFO_LEVEL_EN, omit level_o entirely; all other behaviour is identical.

Verification
REQ-030 Reset, then strobe rx_done_i with 0xA5, 0x3C -> empty_o falls one cycle after first write; two reads return 0xA5 then 0x3C, each with a single rd_valid_o pulse; empty_o=1 afterwards.
REQ-031 Write 16 bytes 0x00..0x0F -> almost_full_o=1 after the 12th, full_o=1 after the 16th; 17th write 0xFF -> overrun_o=1; reads return 0x00..0x0F, 0xFF never appears.
REQ-032 At full, assert rx_done_i=1 (0x55) and rd_en_i=1 together -> read returns oldest byte, 0x55 is stored, full_o stays 1, overrun_o stays 0.
REQ-033 Empty FIFO, rx_done_i=1 (0x77) with rd_en_i=1 -> no rd_valid_o that cycle; 0x77 returned on a following read.
REQ-034 Overrun set, then assert clr_overrun_i alongside another dropped write -> overrun_o stays 1; clr_overrun_i alone next cycle -> overrun_o=0.
REQ-035 Load 5 bytes, pulse reset_i one cycle -> empty_o=1, level_o=0 (when UART_RX_FIFO_LEVEL_EN), overrun_o=0, next read request yields no rd_valid_o.
